// File: rtl/seq_fixed_div.sv
// seq_fixed_div: iterative signed fixed-point restoring divider with valid/ready handshakes.
// Define SEQ_FIXED_DIV_SAT_EN to saturate overflowing quotients instead of wrapping.
module seq_fixed_div #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  overflow,
  output logic                  div_by_zero
);
  localparam int DW = DATA_WIDTH;
  localparam int N  = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0]  LIM_P = (N'(1) << (DW - 1)) - N'(1);
  localparam logic [N-1:0]  LIM_N = N'(1) << (DW - 1);
  localparam logic [DW-1:0] MAXV  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV  = {1'b1, {(DW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_dvd, r_q, w_qn;
  logic [DW:0]     r_rem, w_shift, w_trial, w_rem;
  logic [DW-1:0]   r_bmag, w_amag, w_bmag, w_wrap, w_res, r_quot;
  logic            r_sign, r_ovf, r_dbz, w_bit, w_last, w_ovf, w_bz;
  assign w_amag  = A[DW-1] ? -A : A;
  assign w_bmag  = B[DW-1] ? -B : B;
  assign w_bz    = (B == '0);
  assign w_shift = {r_rem[DW-1:0], r_dvd[N-1]};
  assign w_trial = w_shift - {1'b0, r_bmag};
  assign w_bit   = ~w_trial[DW];
  assign w_rem   = w_bit ? w_trial : w_shift;
  assign w_qn    = {r_q[N-2:0], w_bit};
  assign w_last  = (r_cnt == CW'(N - 1));
  // Negative results may reach one step further than positive ones.
  assign w_ovf   = r_sign ? (w_qn > LIM_N) : (w_qn > LIM_P);
  assign w_wrap  = r_sign ? -w_qn[DW-1:0] : w_qn[DW-1:0];
`ifdef SEQ_FIXED_DIV_SAT_EN
  assign w_res   = w_ovf ? (r_sign ? MINV : MAXV) : w_wrap;
`else
  assign w_res   = w_wrap;
`endif
  assign quotient    = r_quot;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    case (r_state)
      IDLE:    w_next = in_valid ? (w_bz ? DONE : CALC) : IDLE;
      CALC:    w_next = w_last ? DONE : CALC;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_bmag <= '0;
      r_sign <= 1'b0;
      r_quot <= '0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_dvd  <= N'(w_amag) << FRAC_BITS;
      r_bmag <= w_bmag;
      r_sign <= A[DW-1] ^ B[DW-1];
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      if (w_bz) begin
        r_quot <= A[DW-1] ? MINV : MAXV;
        r_ovf  <= 1'b1;
        r_dbz  <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem;
      r_dvd <= r_dvd << 1;
      r_q   <= w_qn;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot <= w_res;
        r_ovf  <= w_ovf;
        r_dbz  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_fixed_div.sv
// tb_seq_fixed_div: directed checks of seq_fixed_div with hand-computed Q8.8 results.
module tb_seq_fixed_div;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic        in_ready, out_valid, overflow, div_by_zero;
  logic [15:0] A, B, quotient;
  int          vecs = 0;
  int          errs = 0;
  int          lat;
  logic [15:0] held_q;
  seq_fixed_div #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    A = a;
    B = b;
    in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_out();
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int elat, input logic [15:0] eq, input logic eo, input logic ez);
    start(a, b);
    wait_out();
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_dbz"}, div_by_zero, ez);
    step();
    chk({tag, "_idle"}, in_ready, 1);
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 16'h0000);
    chk("rst_ovf", overflow, 0);
    chk("rst_dbz", div_by_zero, 0);
    run("pos", 16'h0300, 16'h0200, 25, 16'h0180, 0, 0);
    run("neg", 16'hFD00, 16'h0200, 25, 16'hFE80, 0, 0);
    run("negneg", 16'hFD00, 16'hFE00, 25, 16'h0180, 0, 0);
    run("dbz_pos", 16'h1234, 16'h0000, 1, 16'h7FFF, 1, 1);
    run("dbz_neg", 16'h8000, 16'h0000, 1, 16'h8000, 1, 1);
`ifdef SEQ_FIXED_DIV_SAT_EN
    run("ovf_pos", 16'h7F00, 16'h0001, 25, 16'h7FFF, 1, 0);
    run("ovf_min_neg1", 16'h8000, 16'hFF00, 25, 16'h7FFF, 1, 0);
`else
    run("ovf_pos", 16'h7F00, 16'h0001, 25, 16'h0000, 1, 0);
    run("ovf_min_neg1", 16'h8000, 16'hFF00, 25, 16'h8000, 1, 0);
`endif
    run("min_div1", 16'h8000, 16'h0100, 25, 16'h8000, 0, 0);
    run("zero_num", 16'h0000, 16'hFE00, 25, 16'h0000, 0, 0);
    run("frac", 16'h0100, 16'h0300, 25, 16'h0055, 0, 0);
    out_ready = 1'b0;
    start(16'h0500, 16'h0200);
    wait_out();
    chk("bp_lat", lat, 25);
    chk("bp_q", quotient, 16'h0280);
    held_q = quotient;
    A = 16'h0100; B = 16'h0200; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_q", quotient, held_q);
      chk("bp_hold_ovf", overflow, 0);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_q", quotient, 16'h0280);
    step();
    in_valid = 1'b0;
    chk("bp_second_busy", in_ready, 0);
    wait_out();
    chk("bp_second_lat", lat, 25);
    chk("bp_second_q", quotient, 16'h0080);
    step();
    start(16'h0300, 16'h0100);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_q", quotient, 16'h0000);
    run("after_rst", 16'h0100, 16'h0100, 25, 16'h0100, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/seq_fixed_div.md
Name: seq_fixed_div

Overview:
- Iterative signed fixed-point divider for the ODE solver datapath. It is the inverse arithmetic path to the 2-bit carry-select add/sub unit: it computes quotient = A / B by repeated shift-and-subtract on magnitudes.
- Used for step-size and coefficient normalisation between solver stages.
- Valid/ready handshake on both input and output; one division in flight at a time.

Parameters:
- DATA_WIDTH, 16, width of dividend, divisor and quotient (two's complement); must be even and at least 4.
- FRAC_BITS, 8, number of fractional bits in the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); range 0 to DATA_WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  divider can accept operands.
- A  in  DATA_WIDTH  signed dividend.
- B  in  DATA_WIDTH  signed divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- quotient  out  DATA_WIDTH  signed fixed-point quotient.
- overflow  out  1  quotient not representable; also set on divide-by-zero.
- div_by_zero  out  1  B was zero.

Behaviour:
- Reset (rst_n low at clk edge) returns to IDLE and clears all outputs:
  - in_ready=1, out_valid=0, quotient=0, overflow=0, div_by_zero=0.
  - Internal registers cleared.
  - A reset mid-CALC or mid-DONE aborts the operation with no output.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: in_ready=1. When in_valid=1, latch |A|, |B|, sign=A[msb]^B[msb], and the zero flag (B==0).
    - If B==0, go to DONE; otherwise go to CALC with iteration counter=0.
  - CALC: in_ready=0. Restoring division over N=DATA_WIDTH+FRAC_BITS iterations.
    - The dividend magnitude is left-shifted by FRAC_BITS, so it is N bits wide.
    - Each cycle: shift the partial remainder left by 1 and bring in the next dividend bit. Trial-subtract |B|. If the result is non-negative, keep it and shift in 1; otherwise restore and shift in 0.
    - After the iteration with counter=N-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE. No new operand is accepted in that same cycle.
- Latency:
  - Normal: out_valid rises N+1 cycles after the accepting edge (17+8=25 clocks with defaults).
  - Divide-by-zero: out_valid rises 1 cycle after the accepting edge.
- Magnitudes:
  - |x| is computed as an unsigned DATA_WIDTH value, so -2^(DATA_WIDTH-1) is handled correctly.
  - The unsigned quotient register is N bits wide.
- Rounding: truncation toward zero.
- Sign application: final quotient = sign ? -Qmag : Qmag, truncated to DATA_WIDTH bits.
- Overflow is computed in the CALC->DONE transition:
  - Positive result: overflow=1 if Qmag > 2^(DATA_WIDTH-1)-1.
  - Negative result: overflow=1 if Qmag > 2^(DATA_WIDTH-1).
- Divide-by-zero: div_by_zero=1, overflow=1, quotient saturated by sign of A (0x7FFF if A>=0, 0x8000 if A<0), regardless of the macro.
- Result of zero: A=0 with B!=0 gives quotient=0, overflow=0, no negative zero.
- in_valid while busy is ignored; no handshake completes.

Optional Feature:
- Macro: SEQ_FIXED_DIV_SAT_EN.
- Defined: on overflow (non-zero divisor), quotient saturates to 2^(DATA_WIDTH-1)-1 (positive) or -2^(DATA_WIDTH-1) (negative).
- Undefined: on overflow, quotient is the wrapped low DATA_WIDTH bits of the signed result. The overflow flag is still reported.

Test Plan (DATA_WIDTH=16, FRAC_BITS=8):
1. A=0x0300, B=0x0200 (3.0/2.0), out_ready=1 -> out_valid at accept+25; quotient=0x0180, overflow=0, div_by_zero=0.
2. A=0xFD00, B=0x0200 (-3.0/2.0) -> quotient=0xFE80. Also A=0xFD00, B=0xFE00 -> 0x0180.
3. A=0x1234, B=0x0000 -> out_valid at accept+1; div_by_zero=1, overflow=1, quotient=0x7FFF. A=0x8000, B=0 -> quotient=0x8000.
4. A=0x7F00, B=0x0001 -> overflow=1. Quotient=0x7FFF with SEQ_FIXED_DIV_SAT_EN defined; 0x0000 (wrapped low bits of 0x7F0000) without it.
5. Backpressure: out_ready=0 for 10 cycles after out_valid -> quotient and flags held, in_ready=0, a second in_valid is ignored. out_ready=1 -> IDLE next cycle, then the second operand pair is accepted.
6. rst_n=0 for one cycle at CALC iteration 5 -> next cycle: in_ready=1, out_valid=0, quotient=0. A fresh 0x0100/0x0100 then yields 0x0100.
